// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//   Character output bundle of the UART receive engine.
//
//   Handshake: rx_valid is a one-cycle strobe with no backpressure (there is
//   no ready). On the cycle rx_valid is high, rx_data, parity_err, framing_err
//   and break_det describe the newly received character; they then hold until
//   the next rx_valid strobe. rx_busy is a level status (receiver not idle).
//
//   Signals:
//     rx_data      8-bit received character, LSB-aligned, unused bits 0
//     rx_valid     new-character strobe
//     parity_err   parity mismatch for that character
//     framing_err  stop bit sampled low
//     break_det    data, parity and stop samples all low
//     rx_busy      receiver state is not IDLE
//
//   Modports: master = receiver (drives), slave = consumer (FIFO / regs).
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output framing_err,
        output break_det,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input parity_err,
        input framing_err,
        input break_det,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receive engine driven by a 16x oversampling baud_tick in the
//   uart_clk domain. Synchronises rx_in, qualifies the start bit at mid-bit,
//   samples 5..8 data bits LSB first, optional parity and one stop bit, and
//   presents each character with per-character error flags.
//
//   Ports:
//     uart_clk    clock
//     rst_n       asynchronous active-low reset
//     baud_tick   16x oversampling tick (1-cycle pulse)
//     enable      receiver enable; low forces IDLE synchronously
//     rx_in       asynchronous serial line, idle high
//     data_bits   character length: 0=5, 1=6, 2=7, 3=8 bits
//     parity_en   parity bit present
//     parity_odd  1=odd parity, 0=even
//     rx          character output bundle (uart_rx_if.master)
//     state_dbg   current FSM state encoding (debug visibility)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       enable,
    input  logic       rx_in,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       parity_odd,
    uart_rx_if.master  rx,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [3:0]             cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic [1:0]             db_q;
    logic                   pen_q;
    logic                   podd_q;
    logic                   par_bit_q;
    logic [2:0]             last_idx;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign last_idx  = 3'd4 + {1'b0, db_q};
    assign state_dbg = state;
    assign rx.rx_busy = (state != IDLE);

    // Synchroniser resets to the idle-high line level so reset never looks
    // like a start edge.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bit_idx        <= 3'd0;
            shift_q        <= 8'd0;
            db_q           <= 2'd0;
            pen_q          <= 1'b0;
            podd_q         <= 1'b0;
            par_bit_q      <= 1'b0;
            rx.rx_data     <= 8'd0;
            rx.rx_valid    <= 1'b0;
            rx.parity_err  <= 1'b0;
            rx.framing_err <= 1'b0;
            rx.break_det   <= 1'b0;
        end else begin
            rx.rx_valid <= 1'b0;
            if (!enable) begin
                // Partial character is dropped; output registers hold.
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= 4'd0;
                        end
                    end
                    START: begin
                        if (cnt == 4'd7) begin
                            if (rx_s) begin
                                state <= IDLE;          // false start
                            end else begin
                                // Frame format is frozen here for the whole
                                // character. par_bit_q cleared so break
                                // detection works without parity.
                                state     <= DATA;
                                cnt       <= 4'd0;
                                bit_idx   <= 3'd0;
                                shift_q   <= 8'd0;
                                par_bit_q <= 1'b0;
                                db_q      <= data_bits;
                                pen_q     <= parity_en;
                                podd_q    <= parity_odd;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;              // wraps 15 -> 0
                        if (cnt == 4'd15) begin
                            shift_q[bit_idx] <= rx_s;
                            if (bit_idx == last_idx) begin
                                state <= pen_q ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            par_bit_q <= rx_s;
                            state     <= STOP;
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            rx.rx_valid    <= 1'b1;
                            rx.rx_data     <= shift_q;
                            // Upper unused shift bits are zero, so a full
                            // reduction equals the XOR of the data bits.
                            rx.parity_err  <= pen_q &
                                              (((^shift_q) ^ par_bit_q) != podd_q);
                            rx.framing_err <= ~rx_s;
                            rx.break_det   <= (shift_q == 8'd0) & ~par_bit_q & ~rx_s;
                            state          <= rx_s ? IDLE : WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        // No start detection until the line recovers, so a
                        // held break yields only one character.
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    logic       uart_clk;
    logic       rst_n;
    logic       baud_tick;
    logic       enable;
    logic       rx_in;
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic [2:0] state_dbg;

    uart_rx_if rx_bus ();

    uart_rx #(.SYNC_STAGES(2)) dut (
        .uart_clk   (uart_clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .enable     (enable),
        .rx_in      (rx_in),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx         (rx_bus),
        .state_dbg  (state_dbg)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  valid_cnt = 0;
    time t_last = 0;
    time t_prev = 0;

    // clock / tick
    initial begin
        uart_clk = 1'b0;
        forever #5 uart_clk = ~uart_clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge uart_clk);
            baud_tick = 1'b1;
            @(negedge uart_clk);
            baud_tick = 1'b0;
        end
    end

    // rx_valid monitor, sampled on the falling edge
    always @(negedge uart_clk) begin
        if (rx_bus.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            t_prev    = t_last;
            t_last    = $time;
        end
    end

    // driver tasks
    task automatic wait_tick();
        do @(posedge uart_clk); while (baud_tick !== 1'b1);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic hold_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) wait_tick();
        @(negedge uart_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits,
                              input logic pen, input logic pbit, input logic stopb);
        hold_bit(1'b0, 16);
        for (int i = 0; i < nbits; i++) hold_bit(d[i], 16);
        if (pen) hold_bit(pbit, 16);
        hold_bit(stopb, 16);
    endtask

    task automatic set_fmt(input logic [1:0] db, input logic pen, input logic podd);
        data_bits  = db;
        parity_en  = pen;
        parity_odd = podd;
    endtask

    // scenarios
    task automatic test_reset();
        n_checks++; if (rx_bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_bus.rx_data); end
        n_checks++; if (rx_bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_bus.rx_valid); end
        n_checks++; if ({rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det}); end
        n_checks++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", rx_bus.rx_busy); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    endtask

    task automatic test_8n1();
        int v0;
        set_fmt(2'd3, 1'b0, 1'b0);
        v0 = valid_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL 8n1_pulses: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (rx_bus.rx_data !== 8'hA5) begin n_fail++; $display("FAIL 8n1_data: got %h want a5", rx_bus.rx_data); end
        n_checks++; if ({rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det} !== 3'b000) begin
            n_fail++; $display("FAIL 8n1_flags: got %b want 000", {rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det}); end
        n_checks++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy: got %b want 0", rx_bus.rx_busy); end
    endtask

    task automatic test_parity();
        int v0;
        set_fmt(2'd2, 1'b1, 1'b0);          // 7E1
        v0 = valid_cnt;
        send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1);
        n_checks++; if (rx_bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL 7e1_good_data: got %h want 3c", rx_bus.rx_data); end
        n_checks++; if (rx_bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL 7e1_good_perr: got %b want 0", rx_bus.parity_err); end
        hold_bit(1'b1, 4);
        send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rx_bus.rx_data !== 8'h3C) begin n_fail++; $display("FAIL 7e1_bad_data: got %h want 3c", rx_bus.rx_data); end
        n_checks++; if (rx_bus.parity_err !== 1'b1) begin n_fail++; $display("FAIL 7e1_bad_perr: got %b want 1", rx_bus.parity_err); end
        n_checks++; if (rx_bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL 7e1_bad_ferr: got %b want 0", rx_bus.framing_err); end
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL 7e1_pulses: got %0d want 2", valid_cnt - v0); end
    endtask

    task automatic test_framing();
        int v0;
        set_fmt(2'd0, 1'b1, 1'b1);          // 5O1, 0x15 has three ones -> parity bit 0
        v0 = valid_cnt;
        send_frame(8'h15, 5, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rx_bus.rx_data !== 8'h15) begin n_fail++; $display("FAIL 5o1_data: got %h want 15", rx_bus.rx_data); end
        n_checks++; if ({rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det} !== 3'b010) begin
            n_fail++; $display("FAIL 5o1_flags: got %b want 010", {rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det}); end
        hold_bit(1'b0, 32);
        n_checks++; if (state_dbg !== 3'd5) begin n_fail++; $display("FAIL 5o1_wait_high: got %0d want 5", state_dbg); end
        n_checks++; if (rx_bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL 5o1_busy_low_line: got %b want 1", rx_bus.rx_busy); end
        hold_bit(1'b1, 16);
        n_checks++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL 5o1_busy_recover: got %b want 0", rx_bus.rx_busy); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL 5o1_pulses: got %0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_glitch();
        int v0;
        set_fmt(2'd3, 1'b0, 1'b0);
        v0 = valid_cnt;
        hold_bit(1'b0, 5);
        n_checks++; if (rx_bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_detect: got %b want 1", rx_bus.rx_busy); end
        hold_bit(1'b1, 6);
        n_checks++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_reject: got %b want 0", rx_bus.rx_busy); end
        hold_bit(1'b1, 160);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", valid_cnt - v0); end
    endtask

    task automatic test_break();
        int v0;
        set_fmt(2'd3, 1'b0, 1'b0);
        v0 = valid_cnt;
        hold_bit(1'b0, 480);                // three 8N1 frame times
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL break_pulses: got %0d want 1", valid_cnt - v0); end
        n_checks++; if (rx_bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h want 00", rx_bus.rx_data); end
        n_checks++; if ({rx_bus.framing_err, rx_bus.break_det} !== 2'b11) begin
            n_fail++; $display("FAIL break_flags: got %b want 11", {rx_bus.framing_err, rx_bus.break_det}); end
        hold_bit(1'b1, 16);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL break_next_pulses: got %0d want 2", valid_cnt - v0); end
        n_checks++; if (rx_bus.rx_data !== 8'h55) begin n_fail++; $display("FAIL break_next_data: got %h want 55", rx_bus.rx_data); end
        n_checks++; if ({rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det} !== 3'b000) begin
            n_fail++; $display("FAIL break_next_flags: got %b want 000", {rx_bus.parity_err, rx_bus.framing_err, rx_bus.break_det}); end
    endtask

    task automatic test_abort();
        int v0;
        set_fmt(2'd3, 1'b0, 1'b0);
        // reset during DATA of 0xFF
        v0 = valid_cnt;
        hold_bit(1'b0, 16);
        hold_bit(1'b1, 48);
        rst_n = 1'b0;
        @(negedge uart_clk);
        n_checks++; if (rx_bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", rx_bus.rx_data); end
        n_checks++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", rx_bus.rx_busy); end
        rst_n = 1'b1;
        hold_bit(1'b1, 112);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rst_mid_pulses: got %0d want 0", valid_cnt - v0); end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rx_bus.rx_data !== 8'h81) begin n_fail++; $display("FAIL rst_next_data: got %h want 81", rx_bus.rx_data); end
        // enable drop during DATA of 0xFF
        v0 = valid_cnt;
        hold_bit(1'b0, 16);
        hold_bit(1'b1, 48);
        enable = 1'b0;
        @(negedge uart_clk);
        @(negedge uart_clk);
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL en_mid_state: got %0d want 0", state_dbg); end
        hold_bit(1'b1, 112);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL en_mid_pulses: got %0d want 0", valid_cnt - v0); end
        n_checks++; if (rx_bus.rx_data !== 8'h81) begin n_fail++; $display("FAIL en_mid_hold: got %h want 81", rx_bus.rx_data); end
        enable = 1'b1;
        hold_bit(1'b1, 16);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rx_bus.rx_data !== 8'h81) begin n_fail++; $display("FAIL en_next_data: got %h want 81", rx_bus.rx_data); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL en_next_pulses: got %0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        int v0;
        set_fmt(2'd3, 1'b0, 1'b0);
        hold_bit(1'b1, 16);
        v0 = valid_cnt;
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", valid_cnt - v0); end
        n_checks++; if (rx_bus.rx_data !== 8'h80) begin n_fail++; $display("FAIL b2b_data: got %h want 80", rx_bus.rx_data); end
        n_checks++; if (t_last - t_prev !== 64'd6400) begin n_fail++; $display("FAIL b2b_spacing: got %0t want 6400", t_last - t_prev); end
    endtask

    // main sequence
    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        rx_in  = 1'b1;
        set_fmt(2'd3, 1'b0, 1'b0);
        repeat (5) @(negedge uart_clk);
        test_reset();
        rst_n = 1'b1;
        hold_bit(1'b1, 8);
        test_8n1();
        hold_bit(1'b1, 8);
        test_parity();
        hold_bit(1'b1, 8);
        test_framing();
        test_glitch();
        test_break();
        hold_bit(1'b1, 8);
        test_abort();
        test_back_to_back();
        hold_bit(1'b1, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
